// File: rtl/eth_tx_stats_gen_if.sv
// Byte-wide AXI-Stream bundle for the MAC transmit path.
// The monitor modport observes every signal, including tready, and drives nothing.
interface eth_tx_stats_gen_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tready;
   logic       tlast;
   logic       tuser;

   modport master  (output tdata, tvalid, tlast, tuser, input tready);
   modport slave   (input tdata, tvalid, tlast, tuser, output tready);
   modport monitor (input tdata, tvalid, tready, tlast, tuser);
endinterface

// File: rtl/eth_tx_stats_gen.sv
// Passive per-frame statistics generator for a MAC transmit byte stream.
// Emits one 32-bit statistics word, with a one-cycle strobe, for every frame.
//
// state  | meaning
// IDLE   | between frames, waiting for byte 0
// HDR    | capturing header bytes 1..15 (DA, EtherType, opcode)
// BODY   | past the header, only counting bytes
module eth_tx_stats_gen #(
   parameter int unsigned fcs_bytes = 4,
   parameter logic [15:0] vlan_tpid = 16'h8100
) (
   input  logic                        clk,
   input  logic                        rst,
   eth_tx_stats_gen_if.monitor         s_axis,
   output logic [31:0]                 tx_stats_vector,
   output logic                        tx_stats_valid
);

   localparam logic [1:0]  S_IDLE  = 2'd0;
   localparam logic [1:0]  S_HDR   = 2'd1;
   localparam logic [1:0]  S_BODY  = 2'd2;
   localparam logic [13:0] CNT_MAX = 14'h3FFF;

   logic [1:0]  state;
   logic [13:0] count;
   logic        da_not_ff;
   logic        da_mcast;
   logic [15:0] ethertype;
   logic [15:0] opcode;
   logic        user_seen;

   logic        beat;
   logic [13:0] count_nxt;
   logic        da_not_ff_nxt;
   logic        da_mcast_nxt;
   logic [15:0] ethertype_nxt;
   logic [15:0] opcode_nxt;
   logic        user_nxt;
   logic [14:0] len_sum;
   logic [13:0] len;
   logic        f_good, f_bcast, f_mcast, f_ctrl, f_vlan, f_pause, f_runt;
   logic [31:0] vector_nxt;

   // Header fields and flags as they would stand after the current byte,
   // so a tlast beat reports a frame that includes its own last byte.
   always_comb begin
      beat          = s_axis.tvalid & s_axis.tready;
      count_nxt     = (count == CNT_MAX) ? count : count + 14'd1;
      da_not_ff_nxt = da_not_ff;
      da_mcast_nxt  = da_mcast;
      ethertype_nxt = ethertype;
      opcode_nxt    = opcode;
      user_nxt      = user_seen | s_axis.tuser;

      if (state != S_BODY) begin
         case (count)
            14'd0: begin
               da_not_ff_nxt = da_not_ff | (s_axis.tdata != 8'hFF);
               da_mcast_nxt  = s_axis.tdata[0];
            end
            14'd1, 14'd2, 14'd3, 14'd4, 14'd5:
               da_not_ff_nxt = da_not_ff | (s_axis.tdata != 8'hFF);
            14'd12: ethertype_nxt = {s_axis.tdata, ethertype[7:0]};
            14'd13: ethertype_nxt = {ethertype[15:8], s_axis.tdata};
            14'd14: opcode_nxt    = {s_axis.tdata, opcode[7:0]};
            14'd15: opcode_nxt    = {opcode[15:8], s_axis.tdata};
            default: ;
         endcase
      end

      len_sum = {1'b0, count_nxt} + 15'(fcs_bytes);
      len     = (len_sum > {1'b0, CNT_MAX}) ? CNT_MAX : len_sum[13:0];

      f_good  = ~user_nxt & (count_nxt >= 14'd14);
      f_bcast = (count_nxt >= 14'd6) & ~da_not_ff_nxt;
      f_mcast = (count_nxt >= 14'd6) & da_mcast_nxt & ~f_bcast;
      f_ctrl  = (count_nxt >= 14'd14) & (ethertype_nxt == 16'h8808);
      f_vlan  = (count_nxt >= 14'd14) & (ethertype_nxt == vlan_tpid);
      f_pause = f_ctrl & (count_nxt >= 14'd16) & (opcode_nxt == 16'h0001);
      f_runt  = (count_nxt < 14'd14);

      vector_nxt = {6'd0, f_runt, f_pause, 4'd1, f_vlan, len,
                    f_ctrl, user_nxt, f_mcast, f_bcast, f_good};
   end

   // Frame tracking, parser FSM and the registered statistics output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= S_IDLE;
         count           <= '0;
         da_not_ff       <= 1'b0;
         da_mcast        <= 1'b0;
         ethertype       <= '0;
         opcode          <= '0;
         user_seen       <= 1'b0;
         tx_stats_vector <= '0;
         tx_stats_valid  <= 1'b0;
      end else begin
         tx_stats_valid <= 1'b0;
         if (beat) begin
            if (s_axis.tlast) begin
               tx_stats_vector <= vector_nxt;
               tx_stats_valid  <= 1'b1;
               state           <= S_IDLE;
               count           <= '0;
               da_not_ff       <= 1'b0;
               da_mcast        <= 1'b0;
               ethertype       <= '0;
               opcode          <= '0;
               user_seen       <= 1'b0;
            end else begin
               count     <= count_nxt;
               da_not_ff <= da_not_ff_nxt;
               da_mcast  <= da_mcast_nxt;
               ethertype <= ethertype_nxt;
               opcode    <= opcode_nxt;
               user_seen <= user_nxt;
               case (state)
                  S_IDLE:  state <= S_HDR;
                  S_HDR:   state <= (count == 14'd15) ? S_BODY : S_HDR;
                  default: state <= S_BODY;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_eth_tx_stats_gen.sv
// Testbench for eth_tx_stats_gen: directed and randomized frames checked
// against a frame-level reference model of the statistics word.
module tb_eth_tx_stats_gen;

   localparam int          FCS  = 4;
   localparam logic [15:0] VLAN = 16'h8100;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] tx_stats_vector;
   logic        tx_stats_valid;

   eth_tx_stats_gen_if s_axis ();

   eth_tx_stats_gen #(.fcs_bytes(FCS), .vlan_tpid(VLAN)) dut (
      .clk             (clk),
      .rst             (rst),
      .s_axis          (s_axis),
      .tx_stats_vector (tx_stats_vector),
      .tx_stats_valid  (tx_stats_valid)
   );

   always #5 clk = ~clk;

   logic [7:0]  fb[$];
   bit          fu[$];
   logic [31:0] exp_q[$];
   int          checks  = 0;
   int          errors  = 0;
   int          strobes = 0;
   int          sent    = 0;

   // Reference: statistics word derived from the whole frame's bytes.
   function automatic logic [31:0] model();
      int          n   = fb.size();
      int          cnt = (n > 16383) ? 16383 : n;
      int          ln  = (cnt + FCS > 16383) ? 16383 : cnt + FCS;
      bit          us  = 0;
      bit          bc, mc, ctl, vl, pz, good, runt;
      logic [15:0] et  = 16'h0;
      logic [15:0] op  = 16'h0;
      logic [31:0] v;
      foreach (fu[i]) if (fu[i]) us = 1;
      bc = (n >= 6);
      if (n >= 6) for (int i = 0; i < 6; i++) if (fb[i] != 8'hFF) bc = 0;
      mc = (n >= 6) && fb[0][0] && !bc;
      if (n >= 14) et = {fb[12], fb[13]};
      if (n >= 16) op = {fb[14], fb[15]};
      ctl  = (n >= 14) && (et == 16'h8808);
      vl   = (n >= 14) && (et == VLAN);
      pz   = ctl && (n >= 16) && (op == 16'h0001);
      good = !us && (cnt >= 14);
      runt = (cnt < 14);
      v = 32'(good) | (32'(bc) << 1) | (32'(mc) << 2) | (32'(us) << 3)
        | (32'(ctl) << 4) | (32'(ln) << 5) | (32'(vl) << 19) | (32'd1 << 20)
        | (32'(pz) << 24) | (32'(runt) << 25);
      return v;
   endfunction

   task automatic build_frame(input int len, input logic [47:0] da,
                              input logic [15:0] et, input logic [15:0] op,
                              input int user_pos);
      logic [7:0] b;
      fb.delete();
      fu.delete();
      for (int i = 0; i < len; i++) begin
         if (i < 6)        b = da[47 - 8*i -: 8];
         else if (i == 12) b = et[15:8];
         else if (i == 13) b = et[7:0];
         else if (i == 14) b = op[15:8];
         else if (i == 15) b = op[7:0];
         else              b = 8'($urandom);
         fb.push_back(b);
         fu.push_back(i == user_pos);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      s_axis.tvalid = 1'b0;
      s_axis.tready = 1'b0;
      s_axis.tlast  = 1'b0;
      s_axis.tuser  = 1'b0;
      repeat (n) tick();
   endtask

   // Non-beat cycle with junk on the other lines, including tlast/tuser.
   task automatic stall_cycle();
      if ($urandom_range(0, 1) == 1) begin
         s_axis.tvalid = 1'b1;
         s_axis.tready = 1'b0;
      end else begin
         s_axis.tvalid = 1'b0;
         s_axis.tready = 1'($urandom);
      end
      s_axis.tdata = 8'($urandom);
      s_axis.tlast = 1'($urandom);
      s_axis.tuser = 1'($urandom);
      tick();
   endtask

   task automatic drive_range(input int first, input int last, input int pct);
      for (int i = first; i <= last; i++) begin
         while ($urandom_range(0, 99) < pct) stall_cycle();
         s_axis.tvalid = 1'b1;
         s_axis.tready = 1'b1;
         s_axis.tdata  = fb[i];
         s_axis.tlast  = (i == fb.size() - 1);
         s_axis.tuser  = fu[i];
         tick();
      end
      s_axis.tvalid = 1'b0;
      s_axis.tlast  = 1'b0;
      s_axis.tuser  = 1'b0;
   endtask

   task automatic send(input logic [31:0] exp, input int pct);
      exp_q.push_back(exp);
      sent++;
      drive_range(0, fb.size() - 1, pct);
   endtask

   // Every strobe must match the next expected vector; stray strobes fail.
   always @(negedge clk) begin
      if (tx_stats_valid === 1'b1) begin
         logic [31:0] e;
         strobes++;
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL stray_strobe: observed vector %h expected no strobe", tx_stats_vector);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            assert (tx_stats_vector === e) else begin
               errors++;
               $error("FAIL vector: observed %h expected %h", tx_stats_vector, e);
            end
         end
      end
   end

   task automatic check_reset_state(input string tag);
      @(negedge clk);
      checks++;
      assert (tx_stats_vector === 32'h0) else begin
         errors++;
         $error("FAIL %s_vec: observed %h expected %h", tag, tx_stats_vector, 32'h0);
      end
      checks++;
      assert (tx_stats_valid === 1'b0) else begin
         errors++;
         $error("FAIL %s_valid: observed %b expected %b", tag, tx_stats_valid, 1'b0);
      end
      #1;
   endtask

   initial begin
      logic [47:0] da;
      logic [15:0] et;
      logic [15:0] op;
      int          len;
      int          up;

      rst = 1'b1;
      s_axis.tdata = 8'h0;
      idle(3);
      check_reset_state("reset");
      rst = 1'b0;
      idle(2);

      // 64-byte broadcast, EtherType 0x0800
      build_frame(64, 48'hFFFF_FFFF_FFFF, 16'h0800, 16'h1234, -1);
      send(32'h0010_0883, 20);

      // 60-byte pause frame
      build_frame(60, 48'h0180_C200_0001, 16'h8808, 16'h0001, -1);
      send(32'h0110_0815, 20);

      // 100-byte frame with tuser on beat 50, then a frame starting on the strobe cycle
      build_frame(100, 48'h0200_0000_0001, 16'h0800, 16'h0000, 50);
      send(32'h0010_0D08, 0);
      build_frame(64, 48'h0180_C200_0001, 16'h8100, 16'h0001, -1);
      send(model(), 0);

      // 10-byte runt with broadcast DA
      build_frame(10, 48'hFFFF_FFFF_FFFF, 16'h0000, 16'h0000, -1);
      send(32'h0210_01C2, 10);

      // single-byte frames back to back
      for (int k = 0; k < 5; k++) begin
         build_frame(1, {8'($urandom), 40'h0}, 16'h0, 16'h0, (k == 2) ? 0 : -1);
         send(model(), 0);
      end
      idle(3);

      // 20000-byte frame with stalls: length saturates
      build_frame(20000, 48'h0200_0000_0002, 16'h0800, 16'h0000, -1);
      send(32'h0017_FFE1, 30);
      idle(3);

      // reset at byte 30 discards the frame
      build_frame(64, 48'h0200_0000_0003, 16'h0800, 16'h0000, -1);
      drive_range(0, 29, 10);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      check_reset_state("midframe_rst");
      build_frame(64, 48'h0200_0000_0004, 16'h0800, 16'h0000, -1);
      send(32'h0010_0881, 15);
      idle(3);

      // reset coincident with a tlast beat: no strobe
      build_frame(1, 48'hFFFF_FFFF_FFFF, 16'h0, 16'h0, -1);
      rst = 1'b1;
      s_axis.tvalid = 1'b1;
      s_axis.tready = 1'b1;
      s_axis.tdata  = 8'hFF;
      s_axis.tlast  = 1'b1;
      tick();
      rst = 1'b0;
      idle(1);
      check_reset_state("tlast_rst");
      idle(2);

      // randomized frames
      for (int k = 0; k < 40; k++) begin
         len = $urandom_range(1, 80);
         case ($urandom_range(0, 2))
            0:       da = 48'hFFFF_FFFF_FFFF;
            1:       da = {8'($urandom) | 8'h01, 8'($urandom), 32'($urandom)};
            default: da = {8'($urandom) & 8'hFE, 8'($urandom), 32'($urandom)};
         endcase
         case ($urandom_range(0, 3))
            0:       et = 16'h0800;
            1:       et = 16'h8808;
            2:       et = VLAN;
            default: et = 16'($urandom);
         endcase
         op = ($urandom_range(0, 1) == 1) ? 16'h0001 : 16'($urandom);
         up = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
         build_frame(len, da, et, op, up);
         send(model(), $urandom_range(0, 40));
      end

      idle(6);
      checks++;
      assert (exp_q.size() === 0) else begin
         errors++;
         $error("FAIL missing_strobes: observed %0d pending expected 0", exp_q.size());
      end
      checks++;
      assert (strobes === sent) else begin
         errors++;
         $error("FAIL strobe_count: observed %0d expected %0d", strobes, sent);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
